// File: rtl/adc_host_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_host_multi_pkg
//  Brief    : Shared state encoding, output formats and sizing helper for the
//             multi-lane serial ADC host.
//  Revision : 1.0
// ============================================================================
package adc_host_multi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int FMT_RAW    = 0;
    localparam int FMT_OFFSET = 1;

    // Width able to hold 0..max_count-1, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_shift_lane.sv
`default_nettype none
// ============================================================================
//  Module   : adc_shift_lane
//  Brief    : One ADC data lane: MSB-first shift register with optional
//             offset-binary to two's-complement conversion.
//  Revision : 1.0
// ============================================================================
module adc_shift_lane
    import adc_host_multi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FORMAT = FMT_RAW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              sdo,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (sample_en) begin
            shift_q <= {shift_q[DATA_W-2:0], sdo};
        end
    end

    // Offset binary differs from two's complement only in the sign bit.
    if (FORMAT == FMT_OFFSET) begin : g_offset
        assign word = {~shift_q[DATA_W-1], shift_q[DATA_W-2:0]};
    end else begin : g_raw
        assign word = shift_q;
    end

endmodule
`default_nettype wire

// File: rtl/adc_host_multi.sv
`default_nettype none
// ============================================================================
//  Module   : adc_host_multi
//  Brief    : Host for CHANNELS simultaneous-sampling serial ADCs with shared
//             CONVST/SCLK; emits one aligned word per lane per frame.
//  Revision : 1.0
// ============================================================================
module adc_host_multi
    import adc_host_multi_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int DATA_W     = 16,
    parameter int SCLK_HALF  = 1,
    parameter int CONV_PULSE = 11,
    parameter int CONV_WAIT  = 13,
    parameter int AUTO       = 0,
    parameter int FORMAT     = FMT_RAW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       start,
    output logic                       CONVST,
    output logic                       SCLK,
    input  logic [CHANNELS-1:0]        SDO,
    output logic [CHANNELS*DATA_W-1:0] data,
    output logic                       newdata,
    output logic                       busy,
    output logic                       overrun
);

    localparam int CNT_MAX_A = (CONV_PULSE > CONV_WAIT) ? CONV_PULSE : CONV_WAIT;
    localparam int CNT_MAX   = (CNT_MAX_A > SCLK_HALF) ? CNT_MAX_A : SCLK_HALF;
    localparam int CNT_W     = cnt_width(CNT_MAX);
    localparam int BIT_W     = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_PULSE - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CONV_WAIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam bit               AUTO_MODE = (AUTO != 0);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic                       sclk_q, sclk_d;
    logic                       convst_q;
    logic                       newdata_q;
    logic                       overrun_q;
    logic [CHANNELS*DATA_W-1:0] data_q;
    logic [CHANNELS*DATA_W-1:0] lane_words;
    logic                       sample_en;
    logic                       trigger;

    assign trigger = enable && (AUTO_MODE || start);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sclk_d    = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                end
            end
            ST_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                sclk_d = sclk_q;
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    // Lanes capture on the edge that raises SCLK.
                    if (!sclk_q) begin
                        sample_en = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = ST_DONE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = (AUTO_MODE && enable) ? ST_CONV : ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!enable && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bit_d     = '0;
            sclk_d    = 1'b0;
            sample_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            convst_q  <= 1'b0;
            newdata_q <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            convst_q  <= (state_d == ST_CONV);
            newdata_q <= (state_d == ST_DONE);
            overrun_q <= !AUTO_MODE && start && (state_q != ST_IDLE);
            if (state_d == ST_DONE) begin
                data_q <= lane_words;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        adc_shift_lane #(
            .DATA_W (DATA_W),
            .FORMAT (FORMAT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .sample_en (sample_en),
            .sdo       (SDO[c]),
            .word      (lane_words[c*DATA_W +: DATA_W])
        );
    end

    assign CONVST  = convst_q;
    assign SCLK    = sclk_q;
    assign data    = data_q;
    assign newdata = newdata_q;
    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

endmodule
`default_nettype wire
